vmm_dp: RTL and testbench

Datapath for the vector-matrix-multiply engine, computing C = A·B with A of L×M, B of M×N and C of L×N. It sits directly downstream of the VMM controller FSM and consumes its one-hot-per-cycle control strobes (clear/increment of loop counters i, j, k, accumulator clear/load, C write, phase-2 select). It returns the loop comparator flags and the output-handshake completion flag to the controller. It owns the loop counters, the MAC accumulator, the C register file and the phase-2 output stream of C rows 0..2.

---
 rtl/vmm_pkg.sv | 38 +++
 rtl/vmm_cnt.sv | 43 ++++
 rtl/vmm_dp.sv | 154 +++++++++++++++
 tb/tb_vmm_dp.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vmm_pkg.sv
// Shared definitions for the vector-matrix-multiply engine.
// Holds the controller state encodings (S0..S7), default matrix dimensions and
// width helper functions used by the datapath and the controller.
package vmm_pkg;

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5,
        S6 = 3'd6,
        S7 = 3'd7
    } vmm_state_e;

    localparam int unsigned DefDw = 8;
    localparam int unsigned DefL  = 4;
    localparam int unsigned DefM  = 4;
    localparam int unsigned DefN  = 4;

    function automatic int unsigned vmm_max3(int unsigned a, int unsigned b, int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Loop counters must be able to hold the terminal value (L, M or N itself).
    function automatic int unsigned vmm_cw(int unsigned l, int unsigned m, int unsigned n);
        return $clog2(vmm_max3(l, m, n) + 1);
    endfunction

    // Sum of M full-width products never overflows this width.
    function automatic int unsigned vmm_accw(int unsigned dw, int unsigned m);
        return 2 * dw + $clog2(m + 1);
    endfunction

endpackage

// File: rtl/vmm_cnt.sv
// Loop counter for the VMM datapath.
// Ports:
//   clk, rst_  - clock, asynchronous active-low reset
//   clr_i      - synchronous clear (wins over inc_i)
//   inc_i      - increment by one
//   cnt_o      - current count
// Max is the terminal value; incrementing from Max is a controller bug.
module vmm_cnt #(
    parameter int unsigned CW  = 3,
    parameter int unsigned Max = 4
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [CW-1:0] cnt_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

    inc_in_range_a: assert property (@(posedge clk) disable iff (!rst_)
        (inc_i && !clr_i) |-> (cnt_q < CW'(Max)));

endmodule

// File: rtl/vmm_dp.sv
// Datapath of the vector-matrix-multiply engine, C = A*B (A: LxM, B: MxN).
// Ports:
//   clk, rst_            - clock, asynchronous active-low reset
//   state                - controller state; S7 presents a C element on the output
//   *_ctl inputs         - controller strobes for counters i/j/k, accumulator, C write
//   ilt_l_or_3_ctl, jltn_ctl, kltm_ctl - loop comparator flags back to the controller
//   done_i_ctl           - output handshake completed this cycle
//   a_addr/a_data, b_addr/b_data - combinational-read operand memories
//   out_valid/out_ready/out_data/out_i/out_j - phase-2 stream of C rows 0..2
module vmm_dp import vmm_pkg::*; #(
    parameter int unsigned DW   = DefDw,
    parameter int unsigned L    = DefL,
    parameter int unsigned M    = DefM,
    parameter int unsigned N    = DefN,
    parameter int unsigned CW   = vmm_cw(L, M, N),
    parameter int unsigned ACCW = vmm_accw(DW, M)
) (
    input  logic                   clk,
    input  logic                   rst_,
    input  logic [2:0]             state,
    input  logic                   c_w_en_ctl,
    input  logic                   cl_res_ctl,
    input  logic                   ld_res_ctl,
    input  logic                   cl_i_ctl,
    input  logic                   inc_i_ctl,
    input  logic                   sel_3_ctl,
    input  logic                   cl_j_ctl,
    input  logic                   inc_j_ctl,
    input  logic                   cl_k_ctl,
    input  logic                   inc_k_ctl,
    output logic                   ilt_l_or_3_ctl,
    output logic                   jltn_ctl,
    output logic                   kltm_ctl,
    output logic                   done_i_ctl,
    output logic [$clog2(L*M)-1:0] a_addr,
    input  logic [DW-1:0]          a_data,
    output logic [$clog2(M*N)-1:0] b_addr,
    input  logic [DW-1:0]          b_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACCW-1:0]        out_data,
    output logic [CW-1:0]          out_i,
    output logic [CW-1:0]          out_j
);

    localparam int unsigned AAW = $clog2(L * M);
    localparam int unsigned BAW = $clog2(M * N);

    localparam logic [CW-1:0] LVal     = CW'(L);
    localparam logic [CW-1:0] MVal     = CW'(M);
    localparam logic [CW-1:0] NVal     = CW'(N);
    localparam logic [CW-1:0] RowsOut  = CW'(3);

    logic [CW-1:0]   i_q, j_q, k_q;
    logic [ACCW-1:0] res_q, res_d;
    logic [ACCW-1:0] prod;
    logic [ACCW-1:0] c_q [L][N];

    // ---------------------------------------------------------------- counters
    vmm_cnt #(.CW(CW), .Max(L)) u_cnt_i (
        .clk   (clk),
        .rst_  (rst_),
        .clr_i (cl_i_ctl),
        .inc_i (inc_i_ctl),
        .cnt_o (i_q)
    );

    vmm_cnt #(.CW(CW), .Max(N)) u_cnt_j (
        .clk   (clk),
        .rst_  (rst_),
        .clr_i (cl_j_ctl),
        .inc_i (inc_j_ctl),
        .cnt_o (j_q)
    );

    vmm_cnt #(.CW(CW), .Max(M)) u_cnt_k (
        .clk   (clk),
        .rst_  (rst_),
        .clr_i (cl_k_ctl),
        .inc_i (inc_k_ctl),
        .cnt_o (k_q)
    );

    // --------------------------------------------------------- flags / addresses
    // Phase 2 only streams rows 0..2, so the row bound switches with sel_3.
    assign ilt_l_or_3_ctl = sel_3_ctl ? (i_q < RowsOut) : (i_q < LVal);
    assign jltn_ctl       = (j_q < NVal);
    assign kltm_ctl       = (k_q < MVal);

    // Terminal counter values may wrap the address; nothing is read there.
    assign a_addr = AAW'(i_q) * AAW'(M) + AAW'(k_q);
    assign b_addr = BAW'(k_q) * BAW'(N) + BAW'(j_q);

    // -------------------------------------------------------------- accumulator
    assign prod = ACCW'(a_data) * ACCW'(b_data);

    always_comb begin
        res_d = res_q;
        if (cl_res_ctl) begin
            res_d = '0;
        end else if (ld_res_ctl) begin
            res_d = res_q + prod;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            res_q <= '0;
        end else begin
            res_q <= res_d;
        end
    end

    // ---------------------------------------------------------- C register file
    // Writes take the pre-clear res_q; an index outside LxN matches no entry.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            for (int r = 0; r < L; r++) begin
                for (int c = 0; c < N; c++) begin
                    c_q[r][c] <= '0;
                end
            end
        end else if (c_w_en_ctl) begin
            for (int r = 0; r < L; r++) begin
                for (int c = 0; c < N; c++) begin
                    if (i_q == CW'(r) && j_q == CW'(c)) begin
                        c_q[r][c] <= res_q;
                    end
                end
            end
        end
    end

    c_write_in_range_a: assert property (@(posedge clk) disable iff (!rst_)
        c_w_en_ctl |-> (i_q < LVal && j_q < NVal));

    // ------------------------------------------------------------ output stream
    always_comb begin
        out_data = '0;
        for (int r = 0; r < L; r++) begin
            for (int c = 0; c < N; c++) begin
                if (i_q == CW'(r) && j_q == CW'(c)) begin
                    out_data = c_q[r][c];
                end
            end
        end
    end

    assign out_valid  = (state == S7);
    assign done_i_ctl = out_valid & out_ready;
    assign out_i      = i_q;
    assign out_j      = j_q;

endmodule

// File: tb/tb_vmm_dp.sv
// Self-checking bench for vmm_dp: directed vectors, scoreboard on the output stream.
module tb_vmm_dp;
    import vmm_pkg::*;

    localparam int unsigned DW   = 8;
    localparam int unsigned L    = 4;
    localparam int unsigned M    = 4;
    localparam int unsigned N    = 4;
    localparam int unsigned CW   = 3;
    localparam int unsigned ACCW = 19;
    localparam int unsigned AAW  = 4;
    localparam int unsigned BAW  = 4;

    logic clk = 1'b0;
    logic rst_ = 1'b0;
    logic [2:0] state;
    logic c_w_en_ctl, cl_res_ctl, ld_res_ctl, cl_i_ctl, inc_i_ctl, sel_3_ctl;
    logic cl_j_ctl, inc_j_ctl, cl_k_ctl, inc_k_ctl;
    logic ilt_l_or_3_ctl, jltn_ctl, kltm_ctl, done_i_ctl;
    logic [AAW-1:0] a_addr;
    logic [BAW-1:0] b_addr;
    logic [DW-1:0] a_data, b_data;
    logic out_valid, out_ready;
    logic [ACCW-1:0] out_data;
    logic [CW-1:0] out_i, out_j;

    vmm_dp #(.DW(DW), .L(L), .M(M), .N(N)) dut (
        .clk            (clk),
        .rst_           (rst_),
        .state          (state),
        .c_w_en_ctl     (c_w_en_ctl),
        .cl_res_ctl     (cl_res_ctl),
        .ld_res_ctl     (ld_res_ctl),
        .cl_i_ctl       (cl_i_ctl),
        .inc_i_ctl      (inc_i_ctl),
        .sel_3_ctl      (sel_3_ctl),
        .cl_j_ctl       (cl_j_ctl),
        .inc_j_ctl      (inc_j_ctl),
        .cl_k_ctl       (cl_k_ctl),
        .inc_k_ctl      (inc_k_ctl),
        .ilt_l_or_3_ctl (ilt_l_or_3_ctl),
        .jltn_ctl       (jltn_ctl),
        .kltm_ctl       (kltm_ctl),
        .done_i_ctl     (done_i_ctl),
        .a_addr         (a_addr),
        .a_data         (a_data),
        .b_addr         (b_addr),
        .b_data         (b_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_i          (out_i),
        .out_j          (out_j)
    );

    always #5 clk = ~clk;

    // Operand memories: A all ones, B[k][j] = j+1, or constants for directed tests.
    logic use_mem;
    logic [DW-1:0] a_const, b_const;
    always_comb begin
        a_data = use_mem ? DW'(1) : a_const;
        b_data = use_mem ? DW'(b_addr % BAW'(N)) + DW'(1) : b_const;
    end

    int n_vec = 0;
    int n_err = 0;
    int guard = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    typedef struct packed {
        logic [ACCW-1:0] d;
        logic [CW-1:0]   i;
        logic [CW-1:0]   j;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Monitor: every accepted output beat is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_ && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL stream_unexpected: got data=%0d i=%0d j=%0d, expected no beat",
                         out_data, out_i, out_j);
            end else begin
                mon_e = exp_q.pop_front();
                chk("stream_data", 32'(out_data), 32'(mon_e.d));
                chk("stream_i", 32'(out_i), 32'(mon_e.i));
                chk("stream_j", 32'(out_j), 32'(mon_e.j));
            end
        end
    end

    task automatic clr_ctl();
        c_w_en_ctl = 0; cl_res_ctl = 0; ld_res_ctl = 0; cl_i_ctl = 0; inc_i_ctl = 0;
        cl_j_ctl = 0; inc_j_ctl = 0; cl_k_ctl = 0; inc_k_ctl = 0;
    endtask

    // Apply the strobes set up during this cycle, then drop them.
    task automatic tick();
        @(posedge clk);
        #1;
        clr_ctl();
        guard++;
    endtask

    // Phase 1 controller emulation: fill all of C, driven by the DUT's flags.
    task automatic run_matrix();
        int lim;
        lim = guard + 1000;
        use_mem = 1; state = S1; sel_3_ctl = 0;
        cl_i_ctl = 1; cl_j_ctl = 1; cl_k_ctl = 1; cl_res_ctl = 1;
        tick();
        while (ilt_l_or_3_ctl && guard < lim) begin
            while (jltn_ctl && guard < lim) begin
                state = S2; cl_res_ctl = 1; cl_k_ctl = 1;
                tick();
                while (kltm_ctl && guard < lim) begin
                    state = S3; ld_res_ctl = 1; inc_k_ctl = 1;
                    tick();
                end
                state = S4; c_w_en_ctl = 1; inc_j_ctl = 1;
                tick();
            end
            cl_j_ctl = 1; inc_i_ctl = 1;
            tick();
        end
        chk("matrix_done_ilt", 32'(ilt_l_or_3_ctl), 32'd0);
        state = S0;
    endtask

    // Phase 2 controller emulation: stream rows 0..2 under random out_ready.
    task automatic run_stream();
        int lim, ii, jj;
        logic got;
        lim = guard + 2000;
        ii = 0;
        state = S5; sel_3_ctl = 1; cl_i_ctl = 1; cl_j_ctl = 1;
        tick();
        #1;
        while (ilt_l_or_3_ctl && guard < lim) begin
            jj = 0;
            while (jltn_ctl && guard < lim) begin
                state = S7; sel_3_ctl = 0;
                exp_q.push_back('{d: ACCW'(4 * (jj + 1)), i: CW'(ii), j: CW'(jj)});
                do begin
                    out_ready = 1'($urandom_range(0, 1));
                    #1;
                    got = done_i_ctl;
                    inc_j_ctl = done_i_ctl;
                    tick();
                end while (!got && guard < lim);
                out_ready = 0;
                jj++;
            end
            state = S6; cl_j_ctl = 1; inc_i_ctl = 1;
            tick();
            ii++;
            state = S5; sel_3_ctl = 1;
            #1;
        end
        state = S0; sel_3_ctl = 0; out_ready = 0;
        #1;
        chk("stream_rows", 32'(ii), 32'd3);
        chk("stream_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("stream_s0_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        clr_ctl();
        state = S0; sel_3_ctl = 0; out_ready = 0;
        use_mem = 0; a_const = '0; b_const = '0;
        repeat (2) @(posedge clk);
        #1 rst_ = 1;
        #1;

        // Reset state
        chk("rst_ilt", 32'(ilt_l_or_3_ctl), 32'd1);
        chk("rst_jltn", 32'(jltn_ctl), 32'd1);
        chk("rst_kltm", 32'(kltm_ctl), 32'd1);
        chk("rst_done", 32'(done_i_ctl), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_a_addr", 32'(a_addr), 32'd0);
        chk("rst_b_addr", 32'(b_addr), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);

        // MAC: 4 x (3*5) into C[1][2]
        cl_res_ctl = 1; inc_i_ctl = 1; inc_j_ctl = 1;
        tick();
        inc_j_ctl = 1;
        tick();
        a_const = 8'd3; b_const = 8'd5;
        for (int kk = 0; kk < 4; kk++) begin
            ld_res_ctl = 1; inc_k_ctl = 1;
            #1;
            chk("mac_a_addr", 32'(a_addr), 32'(4 + kk));
            chk("mac_b_addr", 32'(b_addr), 32'(kk * 4 + 2));
            chk("mac_kltm", 32'(kltm_ctl), 32'd1);
            tick();
        end
        chk("mac_kltm_end", 32'(kltm_ctl), 32'd0);
        c_w_en_ctl = 1;
        tick();
        state = S7; out_ready = 1;
        exp_q.push_back('{d: ACCW'(60), i: CW'(1), j: CW'(2)});
        #1;
        chk("mac_done", 32'(done_i_ctl), 32'd1);
        tick();
        state = S0; out_ready = 0;

        // Comparator boundaries and clear-wins
        cl_i_ctl = 1; cl_k_ctl = 1;
        tick();
        repeat (3) begin
            inc_i_ctl = 1;
            tick();
        end
        sel_3_ctl = 0;
        #1;
        chk("ilt_i3_sel0", 32'(ilt_l_or_3_ctl), 32'd1);
        sel_3_ctl = 1;
        #1;
        chk("ilt_i3_sel1", 32'(ilt_l_or_3_ctl), 32'd0);
        chk("a_addr_i3", 32'(a_addr), 32'd12);
        cl_i_ctl = 1; inc_i_ctl = 1;
        tick();
        chk("clr_wins_ilt", 32'(ilt_l_or_3_ctl), 32'd1);
        chk("clr_wins_a_addr", 32'(a_addr), 32'd0);
        sel_3_ctl = 0;
        repeat (2) begin
            inc_j_ctl = 1;
            tick();
        end
        chk("jltn_j4", 32'(jltn_ctl), 32'd0);
        chk("b_addr_j4", 32'(b_addr), 32'd4);
        cl_j_ctl = 1;
        tick();
        chk("jltn_j0", 32'(jltn_ctl), 32'd1);

        // Output held while out_ready low: C[0][1] = 9
        inc_j_ctl = 1;
        tick();
        cl_res_ctl = 1;
        tick();
        a_const = 8'd3; b_const = 8'd3; ld_res_ctl = 1;
        tick();
        c_w_en_ctl = 1;
        tick();
        state = S5;
        #1;
        chk("s5_valid", 32'(out_valid), 32'd0);
        state = S6;
        #1;
        chk("s6_valid", 32'(out_valid), 32'd0);
        state = S7; out_ready = 0;
        repeat (3) begin
            #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), 32'd9);
            chk("hold_done", 32'(done_i_ctl), 32'd0);
            tick();
        end
        out_ready = 1;
        exp_q.push_back('{d: ACCW'(9), i: CW'(0), j: CW'(1)});
        #1;
        chk("hold_release_done", 32'(done_i_ctl), 32'd1);
        tick();
        out_ready = 0; state = S0;

        // Full matrix and phase-2 stream
        run_matrix();
        run_stream();

        // Reset in the middle of a MAC (res = 30)
        use_mem = 0; state = S1;
        cl_res_ctl = 1; cl_i_ctl = 1; cl_j_ctl = 1; cl_k_ctl = 1;
        tick();
        inc_i_ctl = 1;
        tick();
        a_const = 8'd3; b_const = 8'd5;
        ld_res_ctl = 1;
        tick();
        ld_res_ctl = 1;
        tick();
        chk("pre_rst_data", 32'(out_data), 32'd4);
        #1 rst_ = 0;
        state = S0;
        #1;
        chk("midrst_data", 32'(out_data), 32'd0);
        chk("midrst_a_addr", 32'(a_addr), 32'd0);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_ = 1;
        a_const = 8'd2; b_const = 8'd2; ld_res_ctl = 1;
        tick();
        c_w_en_ctl = 1;
        tick();
        state = S7; out_ready = 1;
        exp_q.push_back('{d: ACCW'(4), i: CW'(0), j: CW'(0)});
        tick();
        state = S0; out_ready = 0;

        run_matrix();
        run_stream();

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
